// File: rtl/chain1_master_if.sv
// Bus bundle between the chain1 initiator and its on-chip user / target.
// The master modport is the initiator's view; slave is the far side.
interface chain1_master_if #(
    parameter int WIDTH = 16
);
    logic             i_start;
    logic [WIDTH-1:0] i_data;
    logic             i_sdi;
    logic             o_sclk;
    logic             o_sdo;
    logic             o_load;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_rdata;

    modport master (
        input  i_start,
        input  i_data,
        input  i_sdi,
        output o_sclk,
        output o_sdo,
        output o_load,
        output o_busy,
        output o_done,
        output o_rdata
    );

    modport slave (
        output i_start,
        output i_data,
        output i_sdi,
        input  o_sclk,
        input  o_sdo,
        input  o_load,
        input  o_busy,
        input  o_done,
        input  o_rdata
    );
endinterface

// File: rtl/chain1_master.sv
// Initiator for the chain1 scan interface: shifts a word out MSB first
// under a low load, captures MISO, then raises load to latch the target.
module chain1_master #(
    parameter int WIDTH  = 16,
    parameter int CLKDIV = 2
) (
    input logic             i_clk,
    input logic             i_rst_n,
    chain1_master_if.master bus
);
    localparam int BW = $clog2(WIDTH + 1);
    localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
    localparam logic [BW-1:0] BITS     = BW'(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_LATCH
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] tx;
    logic [WIDTH-1:0] rx;
    logic [BW-1:0]    bit_cnt;
    logic [DW-1:0]    div;
    logic             div_last;
    logic             enter;

    assign div_last = (div == DIV_LAST);
    assign enter    = (state_n != state);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (bus.i_start) state_n = S_SETUP;
            end
            S_SETUP: begin
                if (div_last) state_n = S_HIGH;
            end
            S_HIGH: begin
                if (div_last) state_n = S_LOW;
            end
            S_LOW: begin
                if (div_last) begin
                    state_n = (bit_cnt != '0) ? S_HIGH : S_LATCH;
                end
            end
            S_LATCH: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so every pin is glitch-free
    // and changes on the same edge as the phase it belongs to.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx          <= '0;
            rx          <= '0;
            bit_cnt     <= '0;
            div         <= '0;
            bus.o_sclk  <= 1'b0;
            bus.o_sdo   <= 1'b0;
            bus.o_load  <= 1'b1;
            bus.o_busy  <= 1'b0;
            bus.o_done  <= 1'b0;
            bus.o_rdata <= '0;
        end else begin
            div         <= enter ? '0 : div + 1'b1;
            bus.o_sclk  <= (state_n == S_HIGH);
            bus.o_load  <= (state_n == S_IDLE) || (state_n == S_LATCH);
            bus.o_busy  <= (state_n != S_IDLE);
            bus.o_done  <= (state_n == S_LATCH);
            if (state == S_IDLE && state_n == S_SETUP) begin
                tx        <= bus.i_data;
                rx        <= '0;
                bit_cnt   <= BITS;
                bus.o_sdo <= bus.i_data[WIDTH-1];
            end
            // MISO is sampled here, before the target sees its own rising edge
            if (enter && state_n == S_HIGH) begin
                rx      <= {rx[WIDTH-2:0], bus.i_sdi};
                bit_cnt <= bit_cnt - 1'b1;
            end
            if (enter && state_n == S_LOW) begin
                tx        <= {tx[WIDTH-2:0], 1'b0};
                bus.o_sdo <= tx[WIDTH-2];
            end
            if (enter && state_n == S_LATCH) begin
                bus.o_rdata <= rx;
            end
        end
    end
endmodule
